// File: rtl/control_unit.sv
// control_unit: Lab B processor sequencer and IR decoder (define FETCH_WAIT_EN for a registered-output ROM).
module control_unit #(
  parameter int OPW = 4,
  parameter int DAW = 8,
  parameter int RAW = 4
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [15:0]    IR,
  output logic           PC_clr,
  output logic           PC_up,
  output logic           IR_ld,
  output logic [DAW-1:0] D_addr,
  output logic           D_wr,
  output logic           RF_s,
  output logic [RAW-1:0] RF_W_addr,
  output logic           RF_W_wr,
  output logic [RAW-1:0] RF_Ra_addr,
  output logic [RAW-1:0] RF_Rb_addr,
  output logic [2:0]     ALU_s0,
  output logic [3:0]     State
);
  typedef enum logic [3:0] {
    INIT = 4'd0, FETCH = 4'd1, DECODE = 4'd2, NOOP = 4'd3, LOAD_A = 4'd4, LOAD_B = 4'd5,
    STORE = 4'd6, ADD = 4'd7, SUB = 4'd8, HALT = 4'd9, FETCH_W = 4'd10
  } state_e;
  state_e state_q, state_d;
  logic [OPW-1:0] op;
  assign op = IR[15 -: OPW];
  assign State = state_q;
  always_ff @(posedge Clock) state_q <= Clear ? INIT : state_d;
  always_comb begin
    state_d    = INIT;
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_wr    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = 3'b000;
    case (state_q)
      INIT: begin
        PC_clr  = 1'b1;
        state_d = FETCH;
      end
`ifdef FETCH_WAIT_EN
      FETCH: state_d = FETCH_W;
      FETCH_W: begin
        IR_ld   = 1'b1;
        PC_up   = 1'b1;
        state_d = DECODE;
      end
`else
      FETCH: begin
        IR_ld   = 1'b1;
        PC_up   = 1'b1;
        state_d = DECODE;
      end
`endif
      DECODE: state_d = op == OPW'(2) ? LOAD_A :
                        op == OPW'(1) ? STORE  :
                        op == OPW'(3) ? ADD    :
                        op == OPW'(4) ? SUB    :
                        op == OPW'(5) ? HALT   : NOOP;
      NOOP: state_d = FETCH;
      // LOAD_B repeats LOAD_A's address so the synchronous RAM read lands before the write
      LOAD_A, LOAD_B: begin
        D_addr    = IR[11:4];
        RF_s      = 1'b1;
        RF_W_addr = IR[3:0];
        RF_W_wr   = state_q == LOAD_B;
        state_d   = state_q == LOAD_A ? LOAD_B : FETCH;
      end
      STORE: begin
        D_addr     = IR[7:0];
        RF_Ra_addr = IR[11:8];
        D_wr       = 1'b1;
        state_d    = FETCH;
      end
      ADD, SUB: begin
        RF_Ra_addr = IR[11:8];
        RF_Rb_addr = IR[7:4];
        RF_W_addr  = IR[3:0];
        RF_W_wr    = 1'b1;
        ALU_s0     = state_q == ADD ? 3'b001 : 3'b010;
        state_d    = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = INIT;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors for control_unit; driver queues expected outputs, negedge monitor compares.
module tb_control_unit;
  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [15:0] IR = 16'h0000;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_wr;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State;
  logic [2:0]  ALU_s0;
  logic [32:0] act;
  logic [32:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int step_n = 0;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .State(State)
  );

  always #5 Clock = ~Clock;

  assign act = {State, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr,
                RF_Ra_addr, RF_Rb_addr, ALU_s0};

  function automatic logic [32:0] mk(input logic [3:0] s, input logic clr, input logic up,
                                     input logic ld, input logic [7:0] da, input logic dw,
                                     input logic rs, input logic [3:0] wa, input logic ww,
                                     input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [2:0] alu);
    return {s, clr, up, ld, da, dw, rs, wa, ww, ra, rb, alu};
  endfunction

  function automatic logic [32:0] idle(input logic [3:0] s);
    return mk(s, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
  endfunction

  // Inputs apply for the cycle just begun; e is the output expected during that cycle.
  task automatic step(input logic clr, input logic [15:0] ir, input logic [32:0] e);
    @(posedge Clock);
    #1;
    Clear = clr;
    IR = ir;
    exp_q.push_back(e);
  endtask

  task automatic fetch();
`ifdef FETCH_WAIT_EN
    step(0, 16'h0000, idle(4'd1));
    step(0, 16'h0000, mk(4'd10, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
`else
    step(0, 16'h0000, mk(4'd1, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000));
`endif
  endtask

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      logic [32:0] e;
      e = exp_q.pop_front();
      step_n++;
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL vec%0d state=%0d got=%h exp=%h", step_n, State, act, e);
      end
    end
  end

  initial begin
    logic [32:0] init_e;
    init_e = mk(4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    step(1, 16'h0000, init_e);
    step(0, 16'h0000, init_e);
    fetch();
    step(0, 16'h2A53, idle(4'd2));
    step(0, 16'h2A53, mk(4'd4, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'b000));
    step(0, 16'h2A53, mk(4'd5, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'b000));
    fetch();
    step(0, 16'h3124, idle(4'd2));
    step(0, 16'h3124, mk(4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h4, 1, 4'h1, 4'h2, 3'b001));
    fetch();
    step(0, 16'h4124, idle(4'd2));
    step(0, 16'h4124, mk(4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h4, 1, 4'h1, 4'h2, 3'b010));
    fetch();
    step(0, 16'h1707, idle(4'd2));
    step(0, 16'h1707, mk(4'd6, 0, 0, 0, 8'h07, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'b000));
    fetch();
    step(0, 16'h5000, idle(4'd2));
    for (int i = 0; i < 19; i++) step(0, 16'h5000, idle(4'd9));
    step(1, 16'h5000, idle(4'd9));
    step(0, 16'h0000, init_e);
    fetch();
    step(0, 16'hF000, idle(4'd2));
    step(0, 16'hF000, idle(4'd3));
    fetch();
    step(0, 16'h0000, idle(4'd2));
    step(0, 16'h0000, idle(4'd3));
    fetch();
    step(0, 16'h6ABC, idle(4'd2));
    step(0, 16'h6ABC, idle(4'd3));
    fetch();
    step(0, 16'h2A53, idle(4'd2));
    step(1, 16'h2A53, mk(4'd4, 0, 0, 0, 8'hA5, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'b000));
    step(0, 16'h2A53, init_e);
    fetch();
    step(0, 16'h3124, idle(4'd2));
    step(0, 16'h3124, mk(4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h4, 1, 4'h1, 4'h2, 3'b001));
    repeat (3) @(posedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
